// File: rtl/core_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the core sequencer
// (master) and the memory side (slave).
interface core_sequencer_if;
   logic        imem_req;
   logic        imem_ack;
   logic [15:0] inst_in;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;

   modport master (
      output imem_req,
      input  imem_ack,
      input  inst_in,
      output dmem_req,
      output dmem_we,
      input  dmem_ack
   );

   modport slave (
      input  imem_req,
      output imem_ack,
      output inst_in,
      input  dmem_req,
      input  dmem_we,
      output dmem_ack
   );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the 16-bit core: fetch, decode, execute, memory, writeback,
// with HALT/TRAP stop states, per-access watchdog and a retired-instruction counter.
module core_sequencer #(
   parameter int TIMEOUT  = 16,
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   core_sequencer_if.master    bus,
   output logic [15:0]         ir,
   input  logic                dec_illegal,
   input  logic                dec_halt,
   input  logic                dec_load,
   input  logic                dec_store,
   input  logic                dec_branch,
   output logic                pc_wen,
   output logic                pc_sel_branch,
   output logic                rf_wen_en,
   output logic                csr_wen_en,
   output logic [2:0]          state,
   output logic                halted,
   output logic                trap,
   output logic [1:0]          trap_cause,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_TRAP   = 3'd7
   } state_t;

   localparam int              WDOG_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
   localparam bit              WDOG_ON   = (TIMEOUT != 0);

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
   localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

   state_t                state_r;
   state_t                state_next_s;
   logic [1:0]            cause_next_s;
   logic                  wdog_expire_s;
   logic [WDOG_W-1:0]     wdog_r;
   logic [15:0]           ir_r;
   logic [1:0]            trap_cause_r;
   logic [RETIRE_W-1:0]   retired_r;
   logic                  imem_req_r;
   logic                  dmem_req_r;
   logic                  wb_r;
   logic                  halted_r;
   logic                  trap_r;

   // Watchdog expiry: the current cycle is the last one allowed without an ack.
   always_comb begin
      wdog_expire_s = 1'b0;
      if (WDOG_ON) begin
         wdog_expire_s = (wdog_r == WDOG_LAST);
      end else begin
         wdog_expire_s = 1'b0;
      end
   end

   // Next-state and trap-cause selection; an ack always beats a simultaneous expiry.
   always_comb begin
      state_next_s = state_r;
      cause_next_s = 2'b00;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_next_s = S_FETCH;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_FETCH: begin
            if (bus.imem_ack) begin
               state_next_s = S_DECODE;
            end else if (wdog_expire_s) begin
               state_next_s = S_TRAP;
               cause_next_s = CAUSE_IMEM_TO;
            end else begin
               state_next_s = S_FETCH;
            end
         end
         S_DECODE: begin
            if (dec_illegal) begin
               state_next_s = S_TRAP;
               cause_next_s = CAUSE_ILLEGAL;
            end else if (dec_halt) begin
               state_next_s = S_HALT;
            end else begin
               state_next_s = S_EXEC;
            end
         end
         S_EXEC: begin
            if (dec_load || dec_store) begin
               state_next_s = S_MEM;
            end else begin
               state_next_s = S_WB;
            end
         end
         S_MEM: begin
            if (bus.dmem_ack) begin
               state_next_s = S_WB;
            end else if (wdog_expire_s) begin
               state_next_s = S_TRAP;
               cause_next_s = CAUSE_DMEM_TO;
            end else begin
               state_next_s = S_MEM;
            end
         end
         S_WB:    state_next_s = S_FETCH;
         S_HALT:  state_next_s = S_HALT;
         S_TRAP:  state_next_s = S_TRAP;
         default: state_next_s = S_IDLE;
      endcase
   end

   // State register, IR capture, watchdog, trap cause and retire counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= S_IDLE;
         ir_r         <= 16'h0000;
         wdog_r       <= '0;
         trap_cause_r <= 2'b00;
         retired_r    <= '0;
      end else begin
         state_r <= state_next_s;

         if ((state_r == S_FETCH) && bus.imem_ack) begin
            ir_r <= bus.inst_in;
         end else begin
            ir_r <= ir_r;
         end

         if (state_next_s != state_r) begin
            wdog_r <= '0;
         end else if ((state_r == S_FETCH) || (state_r == S_MEM)) begin
            wdog_r <= wdog_r + WDOG_W'(1);
         end else begin
            wdog_r <= '0;
         end

         if ((state_next_s == S_TRAP) && (state_r != S_TRAP)) begin
            trap_cause_r <= cause_next_s;
         end else begin
            trap_cause_r <= trap_cause_r;
         end

         if (state_r == S_WB) begin
            retired_r <= retired_r + RETIRE_W'(1);
         end else begin
            retired_r <= retired_r;
         end
      end
   end

   // Moore strobes registered from the next state so they line up with state_r.
   always_ff @(posedge clk) begin
      if (rst) begin
         imem_req_r <= 1'b0;
         dmem_req_r <= 1'b0;
         wb_r       <= 1'b0;
         halted_r   <= 1'b0;
         trap_r     <= 1'b0;
      end else begin
         imem_req_r <= (state_next_s == S_FETCH);
         dmem_req_r <= (state_next_s == S_MEM);
         wb_r       <= (state_next_s == S_WB);
         halted_r   <= (state_next_s == S_HALT);
         trap_r     <= (state_next_s == S_TRAP);
      end
   end

   assign bus.imem_req  = imem_req_r;
   assign bus.dmem_req  = dmem_req_r;
   assign bus.dmem_we   = dmem_req_r & dec_store;
   assign pc_wen        = wb_r;
   assign pc_sel_branch = wb_r & dec_branch;
   assign rf_wen_en     = wb_r;
   assign csr_wen_en    = wb_r;
   assign ir            = ir_r;
   assign state         = state_r;
   assign halted        = halted_r;
   assign trap          = trap_r;
   assign trap_cause    = trap_cause_r;
   assign retired       = retired_r;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: an instruction-level model emits the expected per-cycle
// trace, one compare process checks every cycle, and a few literal pins anchor the model.
module tb_core_sequencer;

   localparam int TO = 16;
   localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                          S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_TRAP = 3'd7;

   typedef struct packed {
      logic [2:0]  st;
      logic        imem_req;
      logic        dmem_req;
      logic        dmem_we;
      logic        pc_wen;
      logic        pc_sel;
      logic        rf_en;
      logic        csr_en;
      logic        halted;
      logic        trap;
      logic [1:0]  cause;
      logic [15:0] ir;
      logic [31:0] ret;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] ir;
   logic        dec_illegal, dec_halt, dec_load, dec_store, dec_branch;
   logic        pc_wen, pc_sel_branch, rf_wen_en, csr_wen_en;
   logic [2:0]  state;
   logic        halted, trap;
   logic [1:0]  trap_cause;
   logic [31:0] retired;

   core_sequencer_if bus();

   core_sequencer #(.TIMEOUT(TO), .RETIRE_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus), .ir(ir),
      .dec_illegal(dec_illegal), .dec_halt(dec_halt), .dec_load(dec_load),
      .dec_store(dec_store), .dec_branch(dec_branch),
      .pc_wen(pc_wen), .pc_sel_branch(pc_sel_branch), .rf_wen_en(rf_wen_en),
      .csr_wen_en(csr_wen_en), .state(state), .halted(halted), .trap(trap),
      .trap_cause(trap_cause), .retired(retired)
   );

   always #5 clk = ~clk;

   // Toy decoder: {illegal, halt, load, store, branch}; EFFF flags both illegal and halt.
   function automatic logic [4:0] flags(input logic [15:0] i);
      logic [3:0] op;
      op = i[15:12];
      flags = {(op == 4'hA) || (i == 16'hEFFF), op == 4'hE, op == 4'h8, op == 4'h9, op == 4'hC};
   endfunction

   assign {dec_illegal, dec_halt, dec_load, dec_store, dec_branch} = flags(ir);

   obs_t        exp_q[$];
   obs_t        a_obs, e_obs;
   int          vectors = 0;
   int          miscompares = 0;
   int          cycnt = 0;
   logic [15:0] ir_m, cur_inst;
   logic [31:0] ret_m;
   logic [1:0]  cause_m;
   logic [2:0]  term_m;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e_obs = exp_q.pop_front();
         a_obs = {state, bus.imem_req, bus.dmem_req, bus.dmem_we, pc_wen, pc_sel_branch,
                  rf_wen_en, csr_wen_en, halted, trap, trap_cause, ir, retired};
         vectors++;
         if (a_obs !== e_obs) begin
            miscompares++;
            $display("FAIL trace t=%0t actual=%h required=%h", $time, a_obs, e_obs);
         end
      end
   end

   task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs for it and queue the outputs the rules demand in it.
   task automatic cyc(input logic [2:0] st, input logic s, input logic ia, input logic da,
                      input logic r, input bit chk);
      obs_t       e;
      logic [4:0] f;
      @(posedge clk);
      #1;
      start        = s;
      bus.imem_ack = ia;
      bus.dmem_ack = da;
      rst          = r;
      bus.inst_in  = ia ? cur_inst : ~cur_inst;
      cycnt++;
      f        = flags(ir_m);
      e.st       = st;
      e.imem_req = (st == S_FETCH);
      e.dmem_req = (st == S_MEM);
      e.dmem_we  = (st == S_MEM) && f[1];
      e.pc_wen   = (st == S_WB);
      e.pc_sel   = (st == S_WB) && f[0];
      e.rf_en    = (st == S_WB);
      e.csr_en   = (st == S_WB);
      e.halted   = (st == S_HALT);
      e.trap     = (st == S_TRAP);
      e.cause    = cause_m;
      e.ir       = ir_m;
      e.ret      = ret_m;
      if (chk) exp_q.push_back(e);
   endtask

   task automatic model_reset();
      ir_m    = 16'h0000;
      ret_m   = 32'd0;
      cause_m = 2'b00;
      term_m  = S_IDLE;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, i > 0);
         model_reset();
      end
   endtask

   task automatic go();
      cyc(S_IDLE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // One instruction: fetch ack after iwait stalls, data ack after dwait stalls,
   // optional rst in MEM stall number abort_k.
   task automatic run_inst(input logic [15:0] inst, input int iwait, input int dwait,
                           input int abort_k);
      logic [4:0] f;
      logic       ia, da, r;
      cur_inst = inst;
      term_m   = S_FETCH;
      for (int k = 0; k < TO; k++) begin
         ia = (k == iwait);
         cyc(S_FETCH, 1'b0, ia, 1'b0, 1'b0, 1'b1);
         if (ia) break;
         if (k == TO - 1) begin
            cause_m = 2'b10;
            term_m  = S_TRAP;
            return;
         end
      end
      ir_m = inst;
      f    = flags(inst);
      cyc(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (f[4]) begin
         cause_m = 2'b01;
         term_m  = S_TRAP;
         return;
      end
      if (f[3]) begin
         term_m = S_HALT;
         return;
      end
      cyc(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (f[2] || f[1]) begin
         for (int k = 0; k < TO; k++) begin
            da = (k == dwait);
            r  = (abort_k >= 0) && (k == abort_k);
            cyc(S_MEM, 1'b0, 1'b0, da, r, 1'b1);
            if (r) begin
               model_reset();
               return;
            end
            if (da) break;
            if (k == TO - 1) begin
               cause_m = 2'b11;
               term_m  = S_TRAP;
               return;
            end
         end
      end
      cyc(S_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      ret_m++;
   endtask

   task automatic tail(input int n);
      for (int i = 0; i < n; i++) cyc(term_m, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.inst_in = 16'h0000;
      cur_inst = 16'h0000;
      model_reset();

      // ADD zero-wait, LH with 3 data stalls, SH, taken branch, then HALT ignoring start
      do_reset(2);
      go();
      run_inst(16'h1234, 0, 0, -1);
      run_inst(16'h8010, 2, 3, -1);
      run_inst(16'h9020, 0, 0, -1);
      run_inst(16'hC005, 1, 0, -1);
      run_inst(16'hE000, 0, 0, -1);
      tail(3);
      pin("halt_retired", retired, 32'd4);
      pin("halt_state", 32'(state), 32'd6);
      pin("halt_flag", 32'(halted), 32'd1);
      pin("model_retired", ret_m, 32'd4);

      // illegal opcode traps with cause 01 and commits nothing
      do_reset(2);
      go();
      run_inst(16'h1001, 0, 0, -1);
      run_inst(16'hA000, 0, 0, -1);
      tail(3);
      pin("illegal_cause", 32'(trap_cause), 32'd1);
      pin("illegal_retired", retired, 32'd1);

      // illegal beats halt
      do_reset(1);
      go();
      run_inst(16'hEFFF, 0, 0, -1);
      tail(2);
      pin("prio_halted", 32'(halted), 32'd0);
      pin("prio_cause", 32'(trap_cause), 32'd1);

      // fetch ack on the expiry cycle survives; no ack traps with cause 10
      do_reset(2);
      go();
      run_inst(16'h1111, TO - 1, 0, -1);
      run_inst(16'h2222, TO + 4, 0, -1);
      tail(2);
      pin("imem_to_cause", 32'(trap_cause), 32'd2);
      pin("imem_to_retired", retired, 32'd1);

      // data ack on the expiry cycle survives; no ack traps with cause 11
      do_reset(2);
      go();
      run_inst(16'h8000, 0, TO - 1, -1);
      run_inst(16'h9000, 0, TO + 4, -1);
      tail(2);
      pin("dmem_to_cause", 32'(trap_cause), 32'd3);

      // rst mid-MEM: late acks ignored, then a clean restart
      do_reset(2);
      go();
      run_inst(16'h1003, 0, 0, -1);
      run_inst(16'h8ABC, 0, 99, 2);
      cyc(S_IDLE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      pin("abort_state", 32'(state), 32'd0);
      pin("abort_dmem_req", 32'(bus.dmem_req), 32'd0);
      pin("abort_retired", retired, 32'd0);
      cyc(S_IDLE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      run_inst(16'h1004, 0, 0, -1);
      cyc(S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
